// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
//   Resolves RV32I conditional branches in Execute, registers the outcome
//   into Memory, and keeps a direct-mapped bimodal table of 2-bit
//   saturating counters. Fetch reads the table to predict. Resolved branches
//   train the table. Totals of branches and mispredicts are kept.
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   PCF           Fetch PC; lookup index = PCF[BHT_BITS+1:2]
//   PredTakenF    combinational prediction (MSB of the indexed counter)
//   BranchE       branch op: 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 0/7 none
//   PCE           Execute PC; update index = PCE[BHT_BITS+1:2]
//   PredTakenE    prediction that was made for the Execute instruction
//   A_E, B_E      forwarded rs1/rs2 operands
//   FlushE        squashes the Execute instruction (no resolve, no update)
//   TakenM        registered resolved outcome
//   MispredictM   registered mispredict flag
//   BranchValidM  registered: a valid branch resolved last cycle
//   BranchCount   total resolved branches (wraps)
//   MispredCount  total mispredicted branches (wraps)
module branch_predict_resolve #(
  parameter int XLEN     = 32,
  parameter int BHT_BITS = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  input  logic [2:0]       BranchE,
  input  logic [XLEN-1:0]  PCE,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  A_E,
  input  logic [XLEN-1:0]  B_E,
  input  logic             FlushE,
  output logic             TakenM,
  output logic             MispredictM,
  output logic             BranchValidM,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int unsigned ENTRIES = 1 << BHT_BITS;

  typedef enum logic [2:0] {
    BR_NONE0 = 3'b000,
    BR_EQ    = 3'b001,
    BR_NE    = 3'b010,
    BR_LT    = 3'b011,
    BR_GE    = 3'b100,
    BR_LTU   = 3'b101,
    BR_GEU   = 3'b110,
    BR_NONE7 = 3'b111
  } br_op_e;

  logic [1:0]          r_bht [ENTRIES];
  logic                r_taken_m;
  logic                r_mispred_m;
  logic                r_valid_m;
  logic [CNT_W-1:0]    r_bcnt;
  logic [CNT_W-1:0]    r_mcnt;

  br_op_e              w_op;
  logic [BHT_BITS-1:0] w_fetch_idx;
  logic [BHT_BITS-1:0] w_upd_idx;
  logic                w_eq;
  logic                w_lt;
  logic                w_ltu;
  logic                w_valid;
  logic                w_taken;
  logic                w_mispred;
  logic [1:0]          w_cnt_cur;
  logic [1:0]          w_cnt_nxt;

  assign w_op        = br_op_e'(BranchE);
  assign w_fetch_idx = PCF[BHT_BITS+1:2];
  assign w_upd_idx   = PCE[BHT_BITS+1:2];

  assign w_eq  = (A_E == B_E);
  assign w_lt  = ($signed(A_E) < $signed(B_E));
  assign w_ltu = (A_E < B_E);

  always_comb begin
    w_valid = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      BR_EQ:   begin w_valid = 1'b1; w_taken = w_eq;   end
      BR_NE:   begin w_valid = 1'b1; w_taken = !w_eq;  end
      BR_LT:   begin w_valid = 1'b1; w_taken = w_lt;   end
      BR_GE:   begin w_valid = 1'b1; w_taken = !w_lt;  end
      BR_LTU:  begin w_valid = 1'b1; w_taken = w_ltu;  end
      BR_GEU:  begin w_valid = 1'b1; w_taken = !w_ltu; end
      default: begin w_valid = 1'b0; w_taken = 1'b0;   end
    endcase
    if (FlushE) begin
      w_valid = 1'b0;
      w_taken = 1'b0;
    end
  end

  assign w_mispred = w_valid & (w_taken ^ PredTakenE);

  // Saturating counter step: 00 <-> 01 <-> 10 <-> 11
  assign w_cnt_cur = r_bht[w_upd_idx];
  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    if (w_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'd1;
    end
  end

  // Prediction reads the pre-edge array; no write-to-read bypass.
  assign PredTakenF = r_bht[w_fetch_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (w_valid) begin
      r_bht[w_upd_idx] <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_m   <= 1'b0;
      r_taken_m   <= 1'b0;
      r_mispred_m <= 1'b0;
      r_bcnt      <= '0;
      r_mcnt      <= '0;
    end else begin
      r_valid_m   <= w_valid;
      r_taken_m   <= w_taken;
      r_mispred_m <= w_mispred;
      if (w_valid)   r_bcnt <= r_bcnt + 1'b1;
      if (w_mispred) r_mcnt <= r_mcnt + 1'b1;
    end
  end

  assign TakenM       = r_taken_m;
  assign MispredictM  = r_mispred_m;
  assign BranchValidM = r_valid_m;
  assign BranchCount  = r_bcnt;
  assign MispredCount = r_mcnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;

  localparam int TB_CNT_W = 4;
  localparam int TB_MOD   = 1 << TB_CNT_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         PCF = '0;
  logic                PredTakenF;
  logic [2:0]          BranchE = '0;
  logic [31:0]         PCE = '0;
  logic                PredTakenE = 1'b0;
  logic [31:0]         A_E = '0;
  logic [31:0]         B_E = '0;
  logic                FlushE = 1'b0;
  logic                TakenM;
  logic                MispredictM;
  logic                BranchValidM;
  logic [TB_CNT_W-1:0] BranchCount;
  logic [TB_CNT_W-1:0] MispredCount;

  branch_predict_resolve #(.XLEN(32), .BHT_BITS(6), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
    .BranchE(BranchE), .PCE(PCE), .PredTakenE(PredTakenE),
    .A_E(A_E), .B_E(B_E), .FlushE(FlushE),
    .TakenM(TakenM), .MispredictM(MispredictM), .BranchValidM(BranchValidM),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit v;
    bit t;
    bit m;
    int bc;
    int mc;
  } exp_t;
  exp_t q[$];

  // Reference model: counter values 0..3 per table slot, plain integer totals
  int mbht[64];
  int mbc;
  int mmc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic void model_reset();
    foreach (mbht[i]) mbht[i] = 1;
    mbc = 0;
    mmc = 0;
  endfunction

  function automatic bit ref_taken(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (br)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return sa < sb;
      3'd4: return sa >= sb;
      3'd5: return ua < ub;
      3'd6: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one Execute cycle, check the Fetch prediction against the model
  // before the edge, then push the expected Memory-stage result.
  task automatic drive(input logic [2:0] br, input logic [31:0] pce, input logic [31:0] a,
                       input logic [31:0] b, input bit pt, input bit fl, input logic [31:0] pcf);
    exp_t e;
    bit v, t;
    @(negedge clk);
    BranchE = br; PCE = pce; A_E = a; B_E = b; PredTakenE = pt; FlushE = fl; PCF = pcf;
    #1;
    check("PredTakenF", {31'd0, PredTakenF}, {31'd0, mbht[idx(pcf)] >= 2});
    v = (br >= 3'd1) && (br <= 3'd6) && !fl;
    t = v && ref_taken(br, a, b);
    if (v) begin
      mbht[idx(pce)] = t ? ((mbht[idx(pce)] < 3) ? mbht[idx(pce)] + 1 : 3)
                         : ((mbht[idx(pce)] > 0) ? mbht[idx(pce)] - 1 : 0);
      mbc = mbc + 1;
      if (t != pt) mmc = mmc + 1;
    end
    e.v = v; e.t = t; e.m = v && (t != pt); e.bc = mbc % TB_MOD; e.mc = mmc % TB_MOD;
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, pcf);
  endtask

  // Monitor: one registered result is presented per clock after stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("BranchValidM", {31'd0, BranchValidM}, {31'd0, e.v});
        check("TakenM", {31'd0, TakenM}, {31'd0, e.t});
        check("MispredictM", {31'd0, MispredictM}, {31'd0, e.m});
        check("BranchCount", {28'd0, BranchCount}, e.bc);
        check("MispredCount", {28'd0, MispredCount}, e.mc);
      end
    end
  end

  // Reset while a valid branch sits in Execute: outputs clear at once,
  // the branch is dropped and the table returns to weakly not-taken.
  task automatic reset_mid();
    @(negedge clk);
    BranchE = 3'd1; PCE = 32'h40; A_E = 32'd7; B_E = 32'd7; PredTakenE = 1'b0; FlushE = 1'b0;
    PCF = 32'h40;
    rst = 1'b1;
    #1;
    check("rst_BranchValidM", {31'd0, BranchValidM}, 32'd0);
    check("rst_TakenM", {31'd0, TakenM}, 32'd0);
    check("rst_MispredictM", {31'd0, MispredictM}, 32'd0);
    check("rst_BranchCount", {28'd0, BranchCount}, 32'd0);
    check("rst_MispredCount", {28'd0, MispredCount}, 32'd0);
    check("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, BranchValidM}, 32'd0);
    check("rst_hold_count", {28'd0, BranchCount}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    BranchE = 3'd0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, pce;
    logic [2:0] br;
    bit pt, fl;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_BranchValidM", {31'd0, BranchValidM}, 32'd0);
    check("reset_BranchCount", {28'd0, BranchCount}, 32'd0);
    check("reset_MispredCount", {28'd0, MispredCount}, 32'd0);

    // 1: sweep every index right after reset
    for (int i = 0; i < 64; i++) idle(32'(i) << 2);

    // 2: BEQ equal operands predicted not-taken -> mispredict, counter 10
    drive(3'd1, 32'h40, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0);
    idle(32'h40);
    @(posedge clk); #1;
    check("t2_MispredCount", {28'd0, MispredCount}, 32'd1);
    check("t2_PredTakenF_0x40", {31'd0, PredTakenF}, 32'd1);

    // 3: signed vs unsigned compares with -1 and 1
    drive(3'd3, 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h100);
    drive(3'd5, 32'h104, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h104);
    drive(3'd4, 32'h108, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h108);
    drive(3'd6, 32'h10C, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h10C);

    // 4: saturation at 11, then one not-taken -> 10
    for (int i = 0; i < 4; i++) drive(3'd1, 32'h80, 32'd9, 32'd9, 1'b1, 1'b0, 32'h80);
    drive(3'd2, 32'h80, 32'd9, 32'd9, 1'b1, 1'b0, 32'h80);
    idle(32'h80);

    // 5: flushed and opcode-7 branches never count or train
    drive(3'd2, 32'h200, 32'd1, 32'd2, 1'b0, 1'b1, 32'h200);
    drive(3'd7, 32'h200, 32'd1, 32'd2, 1'b0, 1'b0, 32'h200);
    idle(32'h200);

    // Randomised traffic over a handful of aliasing PCs
    for (int n = 0; n < 400; n++) begin
      br  = 3'($urandom_range(0, 7));
      pce = {$urandom_range(0, 3), 8'h00} | (32'($urandom_range(0, 3)) << 2) | 32'h1000_0000;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) a[31] = ~a[31];
      pt  = ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : (mbht[idx(pce)] >= 2);
      fl  = ($urandom_range(0, 9) == 0);
      drive(br, pce, a, b, pt, fl, ($urandom_range(0, 1) == 1) ? pce : $urandom);
    end

    // 6: reset mid-stream, then 17 valid branches wrap a 4-bit counter to 1
    reset_mid();
    for (int i = 0; i < 17; i++) drive(3'd1, 32'h300, 32'd3, 32'd3, 1'b1, 1'b0, 32'h300);
    @(posedge clk); #1;
    check("t6_wrap_BranchCount", {28'd0, BranchCount}, 32'd1);
    idle(32'h300);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
